// File: rtl/mem_channel_arbiter_pkg.sv
// Shared types and helpers for the two-channel memory arbiter.
package mem_channel_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int NCH = 2;

    // Size is in bits; anything at or beyond the data width writes the whole word.
    function automatic logic [63:0] size_to_mask(input logic [3:0] size, input int data_w);
        if (int'(size) >= data_w) return '1;
        return (64'd1 << size) - 64'd1;
    endfunction

    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base,
                                      input logic [63:0] depth);
        return (addr >= base) && (addr < base + depth);
    endfunction

endpackage

// File: rtl/mem_channel_arbiter_rr.sv
// Two-requester round-robin arbiter: combinational grant while unlocked,
// remembers the owner of the access in flight and steers the pointer.
module rr_arbiter2
    import mem_channel_arbiter_pkg::*;
(
    input  logic           i_clock,
    input  logic           i_rst_n,
    input  logic [NCH-1:0] i_req,
    input  logic           i_lock,
    input  logic           i_done,
    input  logic           i_done_idx,
    output logic           o_gnt_vld,
    output logic           o_gnt_idx,
    output logic           o_owner
);

    logic r_rr;
    logic r_owner;

    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_idx = 1'b0;
        if (!i_lock) begin
            if (i_req == 2'b11) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = r_rr;
            end else if (i_req[0]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = 1'b0;
            end else if (i_req[1]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = 1'b1;
            end
        end
    end

    // Completion always points the pointer away from the channel just served.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr    <= 1'b0;
            r_owner <= 1'b0;
        end else begin
            if (o_gnt_vld) r_owner <= o_gnt_idx;
            if (i_done) r_rr <= ~i_done_idx;
            else if (o_gnt_vld && (&i_req)) r_rr <= ~o_gnt_idx;
        end
    end

    assign o_owner = r_owner;

endmodule

// File: rtl/mem_channel_arbiter.sv
// Arbitrates the accelerator's two master channels onto one synchronous-read
// byte RAM with configurable read/write completion latency.
module mem_channel_arbiter
    import mem_channel_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int BASE_ADDR   = 0,
    parameter int DEPTH       = 128,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NCH-1:0]           m_oe_ram,
    input  logic [NCH-1:0]           m_we_ram,
    input  logic [NCH*ADDR_W-1:0]    m_addr_ram,
    input  logic [NCH*DATA_W-1:0]    m_wdata_ram,
    input  logic [7:0]               m_data_ram_size,
    output logic [NCH*DATA_W-1:0]    m_rdata_ram,
    output logic [NCH-1:0]           m_data_rdy,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [DATA_W-1:0]        mem_wmask,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     proto_err
);

    localparam int MAW = $clog2(DEPTH);
    localparam logic [7:0] RD_L = 8'(READ_DELAY);
    localparam logic [7:0] WR_L = 8'(WRITE_DELAY);

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_k;
    logic                r_is_rd;
    logic                r_proto;
    logic [DATA_W-1:0]   r_rdata [NCH];

    logic [ADDR_W-1:0]   w_addr [NCH];
    logic [NCH-1:0]      w_req;
    logic                w_gnt_vld;
    logic                w_gnt_idx;
    logic                w_owner;
    logic [ADDR_W-1:0]   w_g_addr;
    logic                w_g_rd;
    logic [DATA_W-1:0]   w_g_wdata;
    logic [3:0]          w_g_size;
    logic [7:0]          w_g_lat;
    logic [7:0]          w_lat;
    logic                w_start;
    logic                w_done;
    logic                w_done_idx;
    logic                w_rd_cap;

    // Requests are masked during reset so no strobe can leak combinationally.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_addr[c] = m_addr_ram[c*ADDR_W +: ADDR_W];
            w_req[c]  = reset && (m_oe_ram[c] || m_we_ram[c]) &&
                        in_range(64'(w_addr[c]), 64'(BASE_ADDR), 64'(DEPTH));
        end
    end

    rr_arbiter2 u_arb (
        .i_clock    (clock),
        .i_rst_n    (reset),
        .i_req      (w_req),
        .i_lock     (r_state == BUSY),
        .i_done     (w_done),
        .i_done_idx (w_done_idx),
        .o_gnt_vld  (w_gnt_vld),
        .o_gnt_idx  (w_gnt_idx),
        .o_owner    (w_owner)
    );

    // oe wins when both are raised, so a protocol violation degrades to a read.
    assign w_g_addr  = w_addr[w_gnt_idx];
    assign w_g_rd    = m_oe_ram[w_gnt_idx];
    assign w_g_wdata = w_gnt_idx ? m_wdata_ram[2*DATA_W-1:DATA_W] : m_wdata_ram[DATA_W-1:0];
    assign w_g_size  = w_gnt_idx ? m_data_ram_size[7:4] : m_data_ram_size[3:0];
    assign w_g_lat   = w_g_rd ? RD_L : WR_L;
    assign w_lat     = r_is_rd ? RD_L : WR_L;

    assign w_start    = (r_state == IDLE) && w_gnt_vld;
    assign w_done     = (w_start && (w_g_lat == 8'd1)) || ((r_state == BUSY) && (r_k == w_lat));
    assign w_done_idx = (r_state == IDLE) ? w_gnt_idx : w_owner;
    assign w_rd_cap   = (r_state == BUSY) && r_is_rd && (r_k == 8'd2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start && (w_g_lat != 8'd1)) w_next = BUSY;
            BUSY:    if (r_k == w_lat) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        m_data_rdy = '0;
        if (w_start) begin
            mem_en   = 1'b1;
            mem_we   = !w_g_rd;
            mem_addr = MAW'({1'b0, w_g_addr} - (ADDR_W+1)'(BASE_ADDR));
            if (!w_g_rd) begin
                mem_wdata = w_g_wdata;
                mem_wmask = DATA_W'(size_to_mask(w_g_size, DATA_W));
            end
        end
        if (w_done) m_data_rdy[w_done_idx] = 1'b1;
    end

    // k counts the access cycle; the grant cycle is cycle 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_k     <= 8'd0;
            r_is_rd <= 1'b0;
        end else if (w_start) begin
            r_k     <= 8'd2;
            r_is_rd <= w_g_rd;
        end else if (r_state == BUSY) begin
            r_k     <= r_k + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                     r_proto <= 1'b0;
        else if (|(m_oe_ram & m_we_ram)) r_proto <= 1'b1;
    end

    assign proto_err = r_proto;

    // RAM data arrives in cycle 2: forward it then, and keep it afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) r_rdata[c] <= '0;
        end else if (w_rd_cap) begin
            r_rdata[w_owner] <= mem_rdata;
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            m_rdata_ram[c*DATA_W +: DATA_W] = (w_rd_cap && (w_owner == 1'(c))) ? mem_rdata : r_rdata[c];
        end
    end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Bench for mem_channel_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-timing reference model.
module tb_mem_channel_arbiter;

    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 8;
    localparam int BASE_ADDR   = 0;
    localparam int DEPTH       = 64;
    localparam int READ_DELAY  = 2;
    localparam int WRITE_DELAY = 1;
    localparam int MAW         = $clog2(DEPTH);

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [1:0]            m_oe_ram = '0;
    logic [1:0]            m_we_ram = '0;
    logic [2*ADDR_W-1:0]   m_addr_ram = '0;
    logic [2*DATA_W-1:0]   m_wdata_ram = '0;
    logic [7:0]            m_data_ram_size = '0;
    logic [2*DATA_W-1:0]   m_rdata_ram;
    logic [1:0]            m_data_rdy;
    logic                  mem_en;
    logic                  mem_we;
    logic [MAW-1:0]        mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_wmask;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  proto_err;

    always #5 clock = ~clock;

    mem_channel_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH),
        .READ_DELAY(READ_DELAY), .WRITE_DELAY(WRITE_DELAY)
    ) dut (
        .clock(clock), .reset(reset),
        .m_oe_ram(m_oe_ram), .m_we_ram(m_we_ram), .m_addr_ram(m_addr_ram),
        .m_wdata_ram(m_wdata_ram), .m_data_ram_size(m_data_ram_size),
        .m_rdata_ram(m_rdata_ram), .m_data_rdy(m_data_rdy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .proto_err(proto_err)
    );

    // Synchronous-read RAM macro with bit mask, plus a preload port used during reset.
    logic [7:0]     ram [DEPTH];
    logic           pl_en = 1'b0;
    logic [MAW-1:0] pl_addr = '0;
    logic [7:0]     pl_data = '0;
    always @(posedge clock) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
            else        mem_rdata <= ram[mem_addr];
        end
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", tag, got, exp);
        end
    endtask

    // Master-side state
    bit  ms_pend [2];
    bit  ms_oe   [2];
    bit  ms_we   [2];
    int  ms_addr [2];
    int  ms_wd   [2];
    int  ms_sz   [2];
    int  ms_ttl  [2];
    bit  auto_rd [2];
    int  auto_addr [2];
    bit  rand_mode = 0;
    logic [1:0] last_rdy = '0;

    // Reference model: one access at a time, timed by cycle numbers.
    int         cyc = 0;
    int         free_cyc = 0;
    int         rdy_cyc = -1;
    int         mdl_owner = 0;
    int         mdl_rr = 0;
    bit         mdl_rd = 0;
    logic [7:0] rd_val = '0;
    logic [7:0] hold [2];
    logic [7:0] ref_mem [DEPTH];
    bit         proto_exp = 0;

    function automatic bit in_win(input int a);
        return (a >= BASE_ADDR) && (a < BASE_ADDR + DEPTH);
    endfunction

    function automatic logic [7:0] mask_of(input int sz);
        return (sz >= 8) ? 8'hFF : 8'((1 << sz) - 1);
    endfunction

    task automatic issue(input int c, input bit oe, input bit we, input int addr,
                         input int wd, input int sz, input int ttl);
        ms_pend[c] = 1; ms_oe[c] = oe; ms_we[c] = we; ms_addr[c] = addr;
        ms_wd[c] = wd; ms_sz[c] = sz;
        ms_ttl[c] = in_win(addr) ? -1 : ttl;
    endtask

    task automatic new_rand(input int c);
        int a;
        a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(64, 127)) : int'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1)
            issue(c, 1, 0, a, 0, 0, int'($urandom_range(1, 5)));
        else
            issue(c, 0, 1, a, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                  int'($urandom_range(1, 5)));
    endtask

    task automatic drive();
        for (int c = 0; c < 2; c++) begin
            m_oe_ram[c] = ms_pend[c] & ms_oe[c];
            m_we_ram[c] = ms_pend[c] & ms_we[c];
            m_addr_ram[c*ADDR_W +: ADDR_W] = ADDR_W'(ms_addr[c]);
            m_wdata_ram[c*DATA_W +: DATA_W] = 8'(ms_wd[c]);
            m_data_ram_size[c*4 +: 4] = 4'(ms_sz[c]);
        end
    endtask

    task automatic mdl_reset();
        free_cyc = cyc; rdy_cyc = -1; mdl_rr = 0; proto_exp = 0;
        hold[0] = '0; hold[1] = '0; last_rdy = '0;
    endtask

    task automatic step();
        logic [1:0]     q;
        logic [1:0]     exp_rdy;
        bit             exp_en, exp_we;
        int             g, lat, idx;
        logic [MAW-1:0] exp_addr;
        logic [7:0]     exp_wd, exp_wm;
        @(posedge clock);
        cyc++;
        #2;
        for (int c = 0; c < 2; c++) begin
            if (ms_pend[c] && last_rdy[c]) ms_pend[c] = 0;
            else if (ms_pend[c] && ms_ttl[c] > 0) begin
                ms_ttl[c]--;
                if (ms_ttl[c] == 0) ms_pend[c] = 0;
            end
            if (!ms_pend[c] && auto_rd[c]) issue(c, 1, 0, auto_addr[c], 0, 0, 0);
            else if (!ms_pend[c] && rand_mode && $urandom_range(0, 2) == 0) new_rand(c);
        end
        drive();
        exp_rdy = '0; exp_en = 0; exp_we = 0; exp_addr = '0; exp_wd = '0; exp_wm = '0;
        for (int c = 0; c < 2; c++)
            q[c] = ms_pend[c] && (ms_oe[c] || ms_we[c]) && in_win(ms_addr[c]);
        if (cyc >= free_cyc && q != 2'b00) begin
            g = (q == 2'b11) ? mdl_rr : (q[0] ? 0 : 1);
            mdl_rd = ms_oe[g];
            lat = mdl_rd ? READ_DELAY : WRITE_DELAY;
            mdl_owner = g; rdy_cyc = cyc + lat - 1; free_cyc = cyc + lat; mdl_rr = 1 - g;
            idx = ms_addr[g] - BASE_ADDR;
            exp_en = 1; exp_we = !mdl_rd; exp_addr = MAW'(idx);
            if (mdl_rd) rd_val = ref_mem[idx];
            else begin
                exp_wd = 8'(ms_wd[g]);
                exp_wm = mask_of(ms_sz[g]);
                ref_mem[idx] = (ref_mem[idx] & ~exp_wm) | (exp_wd & exp_wm);
            end
        end
        if (cyc == rdy_cyc) begin
            exp_rdy[mdl_owner] = 1'b1;
            if (mdl_rd) hold[mdl_owner] = rd_val;
        end
        #4;
        chk("data_rdy", m_data_rdy, exp_rdy);
        chk("mem_en", mem_en, exp_en);
        if (exp_en) begin
            chk("mem_we", mem_we, exp_we);
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wmask", mem_wmask, exp_wm);
            if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
        end
        chk("rdata", m_rdata_ram, {hold[1], hold[0]});
        chk("proto_err", proto_err, proto_exp);
        if (|(m_oe_ram & m_we_ram)) proto_exp = 1;
        last_rdy = m_data_rdy;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && (ms_pend[0] || ms_pend[1]); n++) step();
        chk("drain_done", {ms_pend[1], ms_pend[0]}, 2'b00);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"}, m_data_rdy, 0);
        chk({tag, "_rdata"}, m_rdata_ram, 0);
        chk({tag, "_en"}, mem_en, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_wmask"}, mem_wmask, 0);
        chk({tag, "_proto"}, proto_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gseq [$];
        int nr0, nr1;
        logic [7:0] v;
        for (int c = 0; c < 2; c++) begin
            ms_pend[c] = 0; ms_oe[c] = 0; ms_we[c] = 0; ms_addr[c] = 0;
            ms_wd[c] = 0; ms_sz[c] = 0; ms_ttl[c] = -1; auto_rd[c] = 0; auto_addr[c] = 0;
        end
        hold[0] = '0; hold[1] = '0;
        drive();

        // Reset: preload RAM while a request is held, outputs must stay zero
        issue(0, 1, 0, 5, 0, 0, 0);
        drive();
        for (int i = 0; i < DEPTH; i++) begin
            v = (i == 5) ? 8'hA5 : (i == 10) ? 8'hF0 : 8'($urandom_range(0, 255));
            ref_mem[i] = v;
            pl_en = 1'b1; pl_addr = MAW'(i); pl_data = v;
            @(posedge clock);
            #1;
        end
        pl_en = 1'b0;
        chk_all_zero("reset");
        ms_pend[0] = 0;
        drive();
        @(negedge clock) reset = 1'b1;
        mdl_reset();

        // Read of mem[5]
        issue(0, 1, 0, 5, 0, 0, 0);
        step();
        chk("rd_c1_en", mem_en, 1);
        chk("rd_c1_rdy", m_data_rdy, 2'b00);
        step();
        chk("rd_c2_rdy", m_data_rdy, 2'b01);
        chk("rd_c2_en", mem_en, 0);
        chk("rd_c2_data", m_rdata_ram[7:0], 8'hA5);
        drain();

        // Partial write, size 4
        issue(1, 0, 1, 10, 'h3C, 4, 0);
        step();
        chk("wr_rdy", m_data_rdy, 2'b10);
        chk("wr_mask", mem_wmask, 8'h0F);
        drain();
        chk("wr_ram10", ram[10], 8'hFC);

        // Sustained contention
        auto_rd[0] = 1; auto_rd[1] = 1; auto_addr[0] = 20; auto_addr[1] = 21;
        nr0 = 0; nr1 = 0;
        for (int n = 0; n < 60 && gseq.size() < 6; n++) begin
            step();
            if (mem_en) gseq.push_back((mem_addr == MAW'(21)) ? 1 : 0);
            nr0 += int'(m_data_rdy[0]); nr1 += int'(m_data_rdy[1]);
        end
        auto_rd[0] = 0; auto_rd[1] = 0;
        step();
        nr0 += int'(m_data_rdy[0]); nr1 += int'(m_data_rdy[1]);
        chk("cont_ngrant", gseq.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < gseq.size()) chk($sformatf("cont_g%0d", i), gseq[i], i % 2);
        chk("cont_rdy0", nr0, 3);
        chk("cont_rdy1", nr1, 3);
        drain();

        // Out-of-range request
        issue(0, 1, 0, 127, 0, 0, 12);
        for (int n = 0; n < 10; n++) begin
            step();
            chk("oor_rdy", m_data_rdy, 2'b00);
            chk("oor_en", mem_en, 0);
        end
        drain();

        // Randomized traffic
        rand_mode = 1;
        for (int n = 0; n < 2000; n++) step();
        rand_mode = 0;
        drain();

        // Protocol violation on ch1
        issue(1, 1, 1, 3, 'h55, 8, 0);
        step();
        chk("proto_c0", proto_err, 0);
        step();
        chk("proto_c1", proto_err, 1);
        drain();
        for (int n = 0; n < 3; n++) step();
        chk("proto_held", proto_err, 1);

        // Reset during cycle 1 of a ch0 read
        issue(0, 1, 0, 7, 0, 0, 0);
        step();
        chk("rstmid_en", mem_en, 1);
        reset = 1'b0;
        #1;
        chk_all_zero("rstmid");
        ms_pend[0] = 0;
        drive();
        mdl_reset();
        @(posedge clock);
        @(negedge clock) reset = 1'b1;
        issue(1, 1, 0, 9, 0, 0, 0);
        step();
        chk("rstmid_regrant_en", mem_en, 1);
        chk("rstmid_regrant_addr", mem_addr, 9);
        drain();

        for (int i = 0; i < DEPTH; i++) chk($sformatf("ram[%0d]", i), ram[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
